ins_fetch: RTL
==============

# ins_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, including the IF/ID pipeline register. It owns the program counter and fetches instruction words from instruction memory over a req/ack handshake. It presents each instruction and its PC+4 to the decode stage (oins drives decode's iins). It honours the decode-stage load-use stall and the MEM-stage branch/jump redirect, inserting NOP bubbles when no valid instruction is available.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- iStall  in  1  decode-stage hazard stall; holds the IF/ID register and the PC.
- iRedirect  in  1  taken branch or jump from MEM.
- iRedirectPC  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- oImemReq  out  1  fetch request to instruction memory.
- oImemAddr  out  32  fetch address; held stable while oImemReq=1 and iImemAck=0.
- iImemAck  in  1  memory response; may be high in the same cycle as the request (zero-wait).
- iImemData  in  32  instruction word; valid when iImemAck=1.
- oins  out  32  IF/ID instruction to decode.
- oPC4  out  32  IF/ID PC+4 of oins.
- oValid  out  1  IF/ID holds a real instruction; 0 means bubble.
- oFetchCnt  out  32  performance counter (see Configuration).
- oBubbleCnt  out  32  performance counter (see Configuration).

## Operation
- State machine: REQ (request outstanding), HOLD (instruction parked in a skid register while stalled), DRAIN (discarding an in-flight response after a redirect).
- Definition: an accept occurs in a cycle where oImemReq=1 and iImemAck=1.
- REQ:
  - oImemReq=1 and oImemAddr=PC.
  - Accept with iStall=0: load IF/ID with {iImemData, PC+4, valid=1}; PC<=PC+4; stay in REQ.
  - Accept with iStall=1: capture iImemData into the skid register; IF/ID holds; go to HOLD.
  - No accept with iStall=0: load IF/ID with a bubble {32'h0, 32'h0, valid=0}.
  - No accept with iStall=1: IF/ID holds.
- HOLD:
  - oImemReq=0.
  - When iStall falls: load the skid instruction into IF/ID; PC<=PC+4; go to REQ.
- DRAIN:
  - oImemReq=1 with the old address.
  - The response is discarded on accept.
  - IF/ID receives a bubble every cycle unless iStall=1.
  - On accept, go to REQ.
- Redirect has the highest priority and overrides stall:
  - PC<=iRedirectPC & ~3.
  - IF/ID is flushed to a bubble and the skid register is cleared.
  - From REQ with no accept: go to DRAIN.
  - From REQ with an accept: discard the data and stay in REQ.
  - From HOLD: go to REQ.
  - From DRAIN: update the PC and remain in DRAIN.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-operation: any pending response is abandoned. The memory must tolerate oImemReq dropping without an ack, because the reset overrides the handshake.

## Timing
- Reset values:
  - PC=RESET_PC, state=REQ.
  - oins=0, oPC4=0, oValid=0.
  - Both counters 0.
  - oImemReq=0 while rst=1.
- First request: the cycle after rst deasserts.
- With zero-wait memory:
  - The instruction fetched in cycle t appears on oins in cycle t+1.
  - Throughput is 1 instruction per cycle.
- Redirect in cycle t:
  - Target request issues at t+1 (the first cycle after DRAIN completes, if DRAIN is entered).
  - With zero-wait memory, the target instruction is valid at oins in t+2.
- Stall release:
  - Release at cycle t (iStall falls) makes the parked instruction visible at t+1.
  - The next request issues at t+1.

## Configuration
- INS_FETCH_PERF_CNT_EN defined:
  - oFetchCnt increments on every IF/ID load with valid=1.
  - oBubbleCnt increments on every IF/ID load with a bubble, including flushes.
  - Held cycles under stall do not count.
  - Both counters wrap at 2^32 and are cleared by rst.
- INS_FETCH_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package mips_pkg holds:
  - the fetch state enum (REQ, HOLD, DRAIN);
  - the NOP constant 32'h0000_0000;
  - the instruction-width constant (32).
- Sub-module if_id_reg holds the IF/ID register {ins, pc4, valid}, with load, hold and flush controls. ins_fetch contains the PC, the skid register and the FSM.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory -> oImemAddr = 0x100, 0x104, 0x108 on consecutive cycles; oins follows one cycle later with oPC4 = 0x104, 0x108, 0x10C; oValid=1.
- Memory with 2 wait states -> oImemAddr held stable while unacked; two bubbles (oValid=0, oins=0) per instruction; oBubbleCnt=2 per fetch with INS_FETCH_PERF_CNT_EN.
- iStall high for 3 cycles coincident with an accept -> oins unchanged for 3 cycles, oImemReq=0 in HOLD; the parked word appears the cycle after release with no instruction lost or duplicated.
- iRedirect with target 0x2002 while a 2-wait request to 0x40 is pending -> the 0x40 response is discarded; the next request is to 0x2000; IF/ID is a bubble until 0x2000 returns.
- iRedirect and iStall both high in the same cycle -> IF/ID flushed (oValid=0) the next cycle; PC = target.
- rst asserted while in DRAIN -> the next cycle oImemReq=0 and all outputs are at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM states, the NOP encoding,
// the instruction width and a PC alignment helper.
package mips_pkg;

    localparam int INS_W = 32;
    localparam logic [INS_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits are dropped.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Instruction-memory fetch port: the fetch stage is the master, the memory the slave.
interface ins_fetch_if;
    // Handshake: a word transfers in every cycle where oImemReq=1 and iImemAck=1
    // (ack may rise in the request cycle). While oImemReq=1 and iImemAck=0 the master
    // keeps oImemAddr stable; iImemData is meaningful only when iImemAck=1. The master
    // may drop oImemReq without an ack only on reset.
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemData;

    modport master (output oImemReq, output oImemAddr, input iImemAck, input iImemData);
    modport slave  (input oImemReq, input oImemAddr, output iImemAck, output iImemData);
endinterface

// File: rtl/ins_fetch_if_id_reg.sv
// IF/ID pipeline register {ins, pc4, valid}: flush inserts a bubble, load captures a
// real instruction, otherwise the contents hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [INS_W-1:0] d_ins,
    input  logic [31:0]      d_pc4,
    output logic [INS_W-1:0] ins,
    output logic [31:0]      pc4,
    output logic             valid
);

    logic [INS_W-1:0] ins_q, ins_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;

    always_comb begin
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            ins_d   = NOP;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (load) begin
            ins_d   = d_ins;
            pc4_d   = d_pc4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_q   <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign ins   = ins_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/ins_fetch.sv
// MIPS instruction-fetch stage: PC, skid register and REQ/HOLD/DRAIN FSM feeding IF/ID.
// Optional performance counters are built when INS_FETCH_PERF_CNT_EN is defined.
module ins_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iStall,
    input  logic               iRedirect,
    input  logic [31:0]        iRedirectPC,
    ins_fetch_if.master        imem,
    output logic [INS_W-1:0]   oins,
    output logic [31:0]        oPC4,
    output logic               oValid,
    output logic [31:0]        oFetchCnt,
    output logic [31:0]        oBubbleCnt,
    output fetch_state_e       oDbgState
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      drain_addr_q, drain_addr_d;
    logic [INS_W-1:0] skid_q, skid_d;
    logic [INS_W-1:0] load_ins;
    logic [31:0]      pc_plus4;
    logic             req;
    logic             accept;
    logic             ifid_load;
    logic             ifid_flush;

    // No request while parked in HOLD; reset drops the request immediately.
    assign req      = !rst && (state_q != HOLD);
    assign accept   = req && imem.iImemAck;
    assign pc_plus4 = pc_q + 32'd4;

    assign imem.oImemReq  = req;
    // A redirect moves the PC at once, but the abandoned request keeps its address.
    assign imem.oImemAddr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_d       = skid_q;
        load_ins     = imem.iImemData;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;

        if (iRedirect) begin
            pc_d       = pc_align(iRedirectPC);
            skid_d     = NOP;
            ifid_flush = 1'b1;
            case (state_q)
                REQ: begin
                    if (!accept) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:    state_d = REQ;
                // Keep draining until the stale response has actually arrived.
                DRAIN:   if (accept) state_d = REQ;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (accept) begin
                        if (!iStall) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                        end else begin
                            skid_d  = imem.iImemData;
                            state_d = HOLD;
                        end
                    end else if (!iStall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!iStall) begin
                        ifid_load = 1'b1;
                        load_ins  = skid_q;
                        pc_d      = pc_plus4;
                        state_d   = REQ;
                    end
                end
                DRAIN: begin
                    if (!iStall) ifid_flush = 1'b1;
                    if (accept)  state_d    = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            skid_q       <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_q       <= skid_d;
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d_ins (load_ins),
        .d_pc4 (pc_plus4),
        .ins   (oins),
        .pc4   (oPC4),
        .valid (oValid)
    );

    assign oDbgState = state_q;

`ifdef INS_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Only cycles that write IF/ID count; stall-held cycles write nothing.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ifid_load)  fetch_cnt_d  = fetch_cnt_q + 32'd1;
        if (ifid_flush) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign oFetchCnt  = fetch_cnt_q;
    assign oBubbleCnt = bubble_cnt_q;
`else
    assign oFetchCnt  = 32'h0;
    assign oBubbleCnt = 32'h0;
`endif

endmodule
